// File: rtl/ste_slave_regs.sv
// ste_slave_regs
// STEbus slave endpoint exposing an eight-byte I/O register window.
// Registers 0-5 are read/write scratch/control, 6 is a read/write output port
// mirrored on port_out, and 7 is a read-only ID. All bus strobes are
// asynchronous and are resynchronised into clk before use.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   addr      STEbus address A11..A0 (valid while adrstrb low)
//   cm        command modifier {STE cycle, memory/IO, read/write}
//   adrstrb   address strobe, active low, asynchronous
//   datastrb  data strobe, active low, asynchronous
//   data_in   write data from the bus
//   data_out  read data to the bus
//   data_oe   1 = drive data_out onto the bus
//   datack    data acknowledge, active low
//   trferr    transfer error, active low
//   port_out  contents of register 6
module ste_slave_regs #(
  parameter logic [11:0] BASE_ADDR = 12'h040,
  parameter int unsigned ACK_WAIT  = 2,
  parameter logic [7:0]  ID_VALUE  = 8'hA5,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic [2:0]  cm,
  input  logic        adrstrb,
  input  logic        datastrb,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        datack,
  output logic        trferr,
  output logic [7:0]  port_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_IGNORE, S_ADDR, S_WAIT, S_ACCESS, S_ACK, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        as_s1_q, as_s2_q, as_prev_q;
  logic        ds_s1_q, ds_s2_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        rd_q, rd_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        datack_q, datack_d;
  logic        trferr_q, trferr_d;
  logic [7:0]  regs_q [0:6];
  logic [7:0]  regs_d [0:6];

  logic        as_fall;
  logic        hit;

  // Falling edge of the synchronised address strobe; the extra flop keeps
  // IDLE from re-triggering while adrstrb is still held low after a cycle.
  assign as_fall = as_prev_q & ~as_s2_q;
  assign hit     = cm[2] & ~cm[1] & (addr[11:3] == BASE_ADDR[11:3]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    datack_d   = datack_q;
    trferr_d   = trferr_q;
    regs_d     = regs_q;

    case (state_q)
      S_IDLE: begin
        if (as_fall) begin
          idx_d = addr[2:0];
          rd_d  = cm[0];
          if (hit) begin
            state_d = S_ADDR;
            cnt_d   = 4'(TIMEOUT);
          end else begin
            state_d = S_IGNORE;
          end
        end
      end

      S_IGNORE: begin
        if (as_s2_q) state_d = S_IDLE;
      end

      S_ADDR: begin
        // Data strobe wins over a simultaneous address release or timeout.
        if (!ds_s2_q) begin
          state_d = S_WAIT;
          cnt_d   = 4'(ACK_WAIT);
          wdata_d = data_in;
        end else if (as_s2_q) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WAIT: begin
        // The access itself is registered on the way into ACCESS, so the
        // acknowledge and read data are already on the pins during ACCESS.
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
          if (rd_q) begin
            data_out_d = (idx_q == 3'd7) ? ID_VALUE : regs_q[idx_q];
            data_oe_d  = 1'b1;
            datack_d   = 1'b0;
          end else if (idx_q == 3'd7) begin
            trferr_d = 1'b0;
          end else begin
            regs_d[idx_q] = wdata_q;
            datack_d      = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACCESS: begin
        state_d = trferr_q ? S_ACK : S_ERR;
      end

      S_ACK: begin
        if (ds_s2_q) begin
          datack_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_ERR: begin
        if (ds_s2_q) begin
          trferr_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      as_s1_q    <= 1'b1;
      as_s2_q    <= 1'b1;
      as_prev_q  <= 1'b1;
      ds_s1_q    <= 1'b1;
      ds_s2_q    <= 1'b1;
      cnt_q      <= 4'd0;
      idx_q      <= 3'd0;
      rd_q       <= 1'b0;
      wdata_q    <= 8'h00;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      datack_q   <= 1'b1;
      trferr_q   <= 1'b1;
      for (int i = 0; i < 7; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      as_s1_q    <= adrstrb;
      as_s2_q    <= as_s1_q;
      as_prev_q  <= as_s2_q;
      ds_s1_q    <= datastrb;
      ds_s2_q    <= ds_s1_q;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      datack_q   <= datack_d;
      trferr_q   <= trferr_d;
      for (int i = 0; i < 7; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign datack   = datack_q;
  assign trferr   = trferr_q;
  assign port_out = regs_q[6];

endmodule
